// File: rtl/cordic_frame_sched.sv
// cordic_frame_sched: fills a ping-pong waveform buffer during vertical blanking,
// one CORDIC request per display column, and serves the displayed row per pixel.
module cordic_frame_sched #(
  parameter int                 N_COLS      = 80,
  parameter int                 COL_SHIFT   = 3,
  parameter int                 PHASE_W     = 16,
  parameter logic [PHASE_W-1:0] PHASE_STEP  = 16'd819,
  parameter logic [PHASE_W-1:0] SCROLL_STEP = 16'd256,
  parameter int                 TIMEOUT     = 63
) (
  input  logic                clk100,
  input  logic                reset,
  input  logic                vblank_start,
  input  logic [10:0]         h_cnt,
  output logic                cordic_start,
  output logic [PHASE_W-1:0]  cordic_angle,
  input  logic                cordic_done,
  input  logic signed [11:0]  cordic_val,
  output logic [8:0]          plot_row,
  output logic                frame_ready,
  output logic                err_timeout,
  output logic                err_overrun
);

  localparam int         COL_W   = $clog2(N_COLS);
  localparam int         CNT_W   = $clog2(TIMEOUT + 1);
  localparam logic [8:0] NO_PLOT = 9'd511;

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, STORE, SWAP} state_t;

  state_t                state_r;
  logic [COL_W-1:0]      col_r;
  logic [PHASE_W-1:0]    phase_r;
  logic [PHASE_W-1:0]    frame_phase_r;
  logic                  sel_r;
  logic [CNT_W-1:0]      tmo_cnt_r;
  logic signed [11:0]    val_r;
  logic [8:0]            buf_r [0:1][0:N_COLS-1];
  logic [10:0]           idx_s;

  // Screen row for a CORDIC sample: 240 - floor(val*150 / 2048), clamped to the visible 0..479.
  function automatic logic [8:0] calc_row(input logic signed [11:0] val);
    logic signed [19:0] prod;
    logic signed [19:0] row;
    prod = $signed({{8{val[11]}}, val}) * 20'sd150;
    row  = 20'sd240 - (prod >>> 11);
    if (row < 20'sd0) begin
      calc_row = 9'd0;
    end else if (row > 20'sd479) begin
      calc_row = 9'd479;
    end else begin
      calc_row = row[8:0];
    end
  endfunction

  assign idx_s = h_cnt >> COL_SHIFT;

  // Fill sequencer: request, wait, store per column, then swap buffers at the end of the frame.
  always_ff @(posedge clk100) begin
    if (reset) begin
      state_r       <= IDLE;
      col_r         <= '0;
      phase_r       <= '0;
      frame_phase_r <= '0;
      sel_r         <= 1'b0;
      tmo_cnt_r     <= '0;
      val_r         <= '0;
      cordic_start  <= 1'b0;
      cordic_angle  <= '0;
      frame_ready   <= 1'b0;
      err_timeout   <= 1'b0;
      err_overrun   <= 1'b0;
      for (int b = 0; b < 2; b++) begin
        for (int c = 0; c < N_COLS; c++) begin
          buf_r[b][c] <= NO_PLOT;
        end
      end
    end else begin
      cordic_start <= 1'b0;
      frame_ready  <= 1'b0;
      // A new vblank while busy is only flagged; the running fill is left alone.
      if (vblank_start && (state_r != IDLE)) begin
        err_overrun <= 1'b1;
      end
      case (state_r)
        IDLE: begin
          if (vblank_start) begin
            col_r   <= '0;
            phase_r <= frame_phase_r;
            state_r <= ISSUE;
          end
        end
        ISSUE: begin
          cordic_start <= 1'b1;
          cordic_angle <= phase_r;
          tmo_cnt_r    <= '0;
          state_r      <= WAIT;
        end
        WAIT: begin
          // A done in the same cycle as the timeout takes priority.
          if (cordic_done) begin
            val_r   <= cordic_val;
            state_r <= STORE;
          end else if (tmo_cnt_r == CNT_W'(TIMEOUT)) begin
            val_r       <= '0;
            err_timeout <= 1'b1;
            state_r     <= STORE;
          end else begin
            tmo_cnt_r <= tmo_cnt_r + CNT_W'(1);
          end
        end
        STORE: begin
          buf_r[~sel_r][col_r] <= calc_row(val_r);
          if (col_r == COL_W'(N_COLS - 1)) begin
            frame_ready <= 1'b1;
            state_r     <= SWAP;
          end else begin
            col_r   <= col_r + COL_W'(1);
            phase_r <= phase_r + PHASE_STEP;
            state_r <= ISSUE;
          end
        end
        SWAP: begin
          sel_r         <= ~sel_r;
          frame_phase_r <= frame_phase_r + SCROLL_STEP;
          state_r       <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  // Readout of the display buffer for the column under the beam; off-waveform columns show nothing.
  always_ff @(posedge clk100) begin
    if (reset) begin
      plot_row <= NO_PLOT;
    end else if (idx_s < 11'(N_COLS)) begin
      plot_row <= buf_r[sel_r][idx_s[COL_W-1:0]];
    end else begin
      plot_row <= NO_PLOT;
    end
  end

endmodule

// File: tb/tb_cordic_frame_sched.sv
// Directed bench for cordic_frame_sched with a fixed-latency CORDIC model.
module tb_cordic_frame_sched;

  localparam int LAT = 16;

  logic               clk100 = 1'b0;
  logic               reset = 1'b1;
  logic               vblank_start = 1'b0;
  logic [10:0]        h_cnt = 11'd0;
  logic               cordic_start;
  logic [15:0]        cordic_angle;
  logic               cordic_done = 1'b0;
  logic signed [11:0] cordic_val = 12'sd0;
  logic [8:0]         plot_row;
  logic               frame_ready;
  logic               err_timeout;
  logic               err_overrun;

  cordic_frame_sched dut (
    .clk100       (clk100),
    .reset        (reset),
    .vblank_start (vblank_start),
    .h_cnt        (h_cnt),
    .cordic_start (cordic_start),
    .cordic_angle (cordic_angle),
    .cordic_done  (cordic_done),
    .cordic_val   (cordic_val),
    .plot_row     (plot_row),
    .frame_ready  (frame_ready),
    .err_timeout  (err_timeout),
    .err_overrun  (err_overrun)
  );

  always #5 clk100 = ~clk100;

  int cyc = 0;
  always @(posedge clk100) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  // CORDIC model state
  int                 starts = 0;
  int                 frame_base = 0;
  int                 lat_cnt = 0;
  int                 drop_col = -1;
  int                 vals [0:79];
  logic signed [11:0] resp_val = 12'sd0;
  bit                 resp_drop = 1'b0;
  logic [15:0]        angles [$];
  int                 start_cyc [$];

  int fr_count = 0;
  int fr_cyc = 0;

  typedef struct {
    int          frame;
    logic [10:0] h;
    logic [8:0]  exp;
  } vec_t;
  vec_t vecs [0:19];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // CORDIC responder: answers each start LAT cycles later unless the column is marked dropped.
  always @(negedge clk100) begin
    cordic_done = 1'b0;
    if (lat_cnt > 0) begin
      lat_cnt--;
      if (lat_cnt == 0 && !resp_drop) begin
        cordic_done = 1'b1;
        cordic_val  = resp_val;
      end
    end
    if (cordic_start === 1'b1) begin
      int c;
      c = starts - frame_base;
      angles.push_back(cordic_angle);
      start_cyc.push_back(cyc);
      starts++;
      resp_val  = (c >= 0 && c < 80) ? 12'(vals[c]) : 12'sd0;
      resp_drop = (c == drop_col);
      lat_cnt   = LAT;
    end
  end

  // frame_ready monitor
  always @(negedge clk100) begin
    if (frame_ready === 1'b1) begin
      fr_count++;
      fr_cyc = cyc;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk100);
  endtask

  task automatic pulse_vblank();
    vblank_start = 1'b1;
    @(negedge clk100);
    vblank_start = 1'b0;
  endtask

  task automatic wait_frame(input int prev, input string name);
    for (int i = 0; i < 4000 && fr_count == prev; i++) @(negedge clk100);
    check(name, fr_count, prev + 1);
  endtask

  task automatic read_row(input logic [10:0] h, input logic [8:0] exp, input string name);
    h_cnt = h;
    @(negedge clk100);
    check(name, plot_row, exp);
  endtask

  task automatic apply_table(input int frame);
    for (int i = 0; i < 20; i++) begin
      if (vecs[i].frame == frame) begin
        read_row(vecs[i].h, vecs[i].exp, $sformatf("f%0d_row_h%0d", frame, vecs[i].h));
      end
    end
  endtask

  initial begin
    int vb_cyc;
    int lat;
    int t5;
    int sb;

    // Frame 1 vectors (values: c0=2047 c1=-2048 c2=0 c3=-1 c4=13 c40=500 c78=-14 c79=1000)
    vecs[0]  = '{1, 11'd0,    9'd91};
    vecs[1]  = '{1, 11'd8,    9'd390};
    vecs[2]  = '{1, 11'd16,   9'd240};
    vecs[3]  = '{1, 11'd7,    9'd91};
    vecs[4]  = '{1, 11'd24,   9'd241};
    vecs[5]  = '{1, 11'd32,   9'd240};
    vecs[6]  = '{1, 11'd320,  9'd204};
    vecs[7]  = '{1, 11'd624,  9'd242};
    vecs[8]  = '{1, 11'd632,  9'd167};
    vecs[9]  = '{1, 11'd639,  9'd167};
    vecs[10] = '{1, 11'd640,  9'd511};
    vecs[11] = '{1, 11'd2047, 9'd511};
    // Frame 2 vectors (all values -1000, column 5 timed out)
    vecs[12] = '{2, 11'd7,    9'd314};
    vecs[13] = '{2, 11'd0,    9'd314};
    vecs[14] = '{2, 11'd40,   9'd240};
    vecs[15] = '{2, 11'd47,   9'd240};
    vecs[16] = '{2, 11'd48,   9'd314};
    vecs[17] = '{2, 11'd639,  9'd314};
    vecs[18] = '{2, 11'd640,  9'd511};
    vecs[19] = '{2, 11'd1000, 9'd511};

    for (int i = 0; i < 80; i++) vals[i] = 0;

    // Reset
    reset = 1'b1;
    tick(2);
    check("rst_plot_row", plot_row, 511);
    check("rst_cordic_start", cordic_start, 0);
    check("rst_err_timeout", err_timeout, 0);
    check("rst_err_overrun", err_overrun, 0);
    reset = 1'b0;
    tick(20);
    check("idle_no_frame_ready", fr_count, 0);
    check("idle_no_starts", starts, 0);
    check("idle_plot_row", plot_row, 511);

    // Frame 1: nominal fill
    vals[0] = 2047; vals[1] = -2048; vals[2] = 0; vals[3] = -1; vals[4] = 13;
    vals[40] = 500; vals[78] = -14; vals[79] = 1000;
    drop_col = -1;
    frame_base = starts;
    vb_cyc = cyc;
    pulse_vblank();
    wait_frame(0, "f1_frame_ready");
    lat = fr_cyc - vb_cyc;
    check("f1_fill_latency_in_1518_1522", (lat >= 1518 && lat <= 1522) ? 1 : 0, 1);
    check("f1_starts", starts, 80);
    for (int k = 0; k < 80; k++) check($sformatf("f1_angle%0d", k), angles[k], (k * 819) & 16'hFFFF);
    check("f1_err_timeout", err_timeout, 0);
    check("f1_err_overrun", err_overrun, 0);
    tick(2);
    apply_table(1);

    // Frame 2: scroll, timeout on column 5, overrun, no tearing
    for (int i = 0; i < 80; i++) vals[i] = -1000;
    drop_col = 5;
    frame_base = starts;
    h_cnt = 11'd0;
    pulse_vblank();
    for (int i = 0; i < 100 && starts < 81; i++) @(negedge clk100);
    check("f2_first_start_seen", (starts >= 81) ? 1 : 0, 1);
    check("f2_first_angle", angles[80], 256);
    for (int i = 0; i < 500 && starts < 86; i++) @(negedge clk100);
    check("f2_col5_start_seen", (starts >= 86) ? 1 : 0, 1);
    t5 = start_cyc[85];
    check("f2_no_tear_a", plot_row, 91);
    for (int i = 0; i < 200 && cyc < t5 + 63; i++) @(negedge clk100);
    check("f2_timeout_not_yet", err_timeout, 0);
    @(negedge clk100);
    check("f2_timeout_at_64", err_timeout, 1);
    sb = starts;
    pulse_vblank();
    check("f2_err_overrun", err_overrun, 1);
    tick(100);
    check("f2_no_restart_progress", (starts > sb) ? 1 : 0, 1);
    check("f2_no_swap_yet", fr_count, 1);
    read_row(11'd0, 9'd91, "f2_no_tear_b");
    read_row(11'd639, 9'd167, "f2_no_tear_c");
    wait_frame(1, "f2_frame_ready");
    check("f2_total_starts", starts, 160);
    for (int k = 0; k < 80; k++) check($sformatf("f2_angle%0d", k), angles[80 + k], (256 + k * 819) & 16'hFFFF);
    check("f2_timeout_sticky", err_timeout, 1);
    check("f2_overrun_sticky", err_overrun, 1);
    tick(2);
    apply_table(2);

    // Reset in the middle of a fill: no swap, everything back to reset values
    drop_col = -1;
    frame_base = starts;
    pulse_vblank();
    tick(200);
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    sb = starts;
    tick(100);
    check("mid_rst_no_swap", fr_count, 2);
    check("mid_rst_no_starts", starts, sb);
    check("mid_rst_err_timeout", err_timeout, 0);
    check("mid_rst_err_overrun", err_overrun, 0);
    read_row(11'd0, 9'd511, "mid_rst_row_c0");
    read_row(11'd639, 9'd511, "mid_rst_row_c79");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
